tank_round_ctrl: RTL and testbench



---
 rtl/tank_round_ctrl.sv | 170 +++++++++++++++++
 tb/tb_tank_round_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tank_round_ctrl.sv
// Round sequencer for the two-player tank game: countdown, per-frame hit detection,
// scoring, hit pause and game-over handling.
module tank_round_ctrl #(
  parameter logic [3:0] WIN_SCORE    = 4'd5,
  parameter logic [7:0] COUNT_FRAMES = 8'd180,
  parameter logic [7:0] HIT_FRAMES   = 8'd60,
  parameter logic [9:0] TANK_W       = 10'd32,
  parameter logic [9:0] TANK_H       = 10'd32,
  parameter logic [9:0] BULLET_W     = 10'd8,
  parameter logic [9:0] BULLET_H     = 10'd8,
  parameter logic [7:0] START_KEY    = 8'h28
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] tank0_X,
  input  logic [9:0] tank0_Y,
  input  logic [9:0] tank1_X,
  input  logic [9:0] tank1_Y,
  input  logic [9:0] bullet0_X,
  input  logic [9:0] bullet0_Y,
  input  logic [9:0] bullet1_X,
  input  logic [9:0] bullet1_Y,
  input  logic       bullet0_active,
  input  logic       bullet1_active,
  output logic [1:0] tank_reset,
  output logic [1:0] bullet_kill,
  output logic       freeze,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [2:0] state,
  output logic [7:0] frames_left,
  output logic       winner
);

  typedef enum logic [2:0] {
    StAttract   = 3'd0,
    StCountdown = 3'd1,
    StPlay      = 3'd2,
    StHit       = 3'd3,
    StGameOver  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] score0_q, score0_d, score1_q, score1_d;
  logic [7:0] frames_q, frames_d;
  logic       winner_q, winner_d;
  logic [1:0] kill_q, kill_d;
  logic       key_armed_q, key_armed_d;
  logic [1:0] sync_q;
  logic       frame_prev_q;
  logic       fe, start_ok, h0, h1;

  // Inclusive box overlap on 11-bit sums so right/bottom edges never wrap.
  function automatic logic overlap(input logic [9:0] bx, input logic [9:0] by,
                                   input logic [9:0] tx, input logic [9:0] ty);
    logic [10:0] bx_e, by_e, tx_e, ty_e;
    bx_e = {1'b0, bx};
    by_e = {1'b0, by};
    tx_e = {1'b0, tx};
    ty_e = {1'b0, ty};
    return (bx_e + {1'b0, BULLET_W} >= tx_e) && (bx_e <= tx_e + {1'b0, TANK_W}) &&
           (by_e + {1'b0, BULLET_H} >= ty_e) && (by_e <= ty_e + {1'b0, TANK_H});
  endfunction

  assign fe       = sync_q[1] & ~frame_prev_q;
  assign start_ok = key_armed_q && (keycode == START_KEY);
  assign h0       = bullet0_active && overlap(bullet0_X, bullet0_Y, tank1_X, tank1_Y);
  assign h1       = bullet1_active && overlap(bullet1_X, bullet1_Y, tank0_X, tank0_Y);

  always_comb begin
    state_d  = state_q;
    score0_d = score0_q;
    score1_d = score1_q;
    frames_d = frames_q;
    winner_d = winner_q;
    kill_d   = kill_q;
    case (state_q)
      StAttract, StGameOver: begin
        if (start_ok) begin
          score0_d = 4'd0;
          score1_d = 4'd0;
          frames_d = COUNT_FRAMES;
          state_d  = StCountdown;
        end
      end
      StCountdown: begin
        if (fe) begin
          if (frames_q <= 8'd1) begin
            frames_d = 8'd0;
            state_d  = StPlay;
          end else begin
            frames_d = frames_q - 8'd1;
          end
        end
      end
      StPlay: begin
        if (fe && (h0 || h1)) begin
          if (h0 && !h1 && score0_q != WIN_SCORE) score0_d = score0_q + 4'd1;
          if (h1 && !h0 && score1_q != WIN_SCORE) score1_d = score1_q + 4'd1;
          kill_d   = 2'b11;
          frames_d = HIT_FRAMES;
          state_d  = StHit;
        end
      end
      StHit: begin
        if (fe) begin
          if (frames_q <= 8'd1) begin
            kill_d = 2'b00;
            if (score0_q == WIN_SCORE || score1_q == WIN_SCORE) begin
              winner_d = (score1_q == WIN_SCORE);
              frames_d = 8'd0;
              state_d  = StGameOver;
            end else begin
              frames_d = COUNT_FRAMES;
              state_d  = StCountdown;
            end
          end else begin
            frames_d = frames_q - 8'd1;
          end
        end
      end
      default: state_d = StAttract;
    endcase

    // Any state entry disarms the start key until the keyboard reports no key.
    if (state_d != state_q) begin
      key_armed_d = 1'b0;
    end else if (keycode == 8'd0) begin
      key_armed_d = 1'b1;
    end else begin
      key_armed_d = key_armed_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StAttract;
      score0_q     <= 4'd0;
      score1_q     <= 4'd0;
      frames_q     <= 8'd0;
      winner_q     <= 1'b0;
      kill_q       <= 2'b00;
      key_armed_q  <= 1'b0;
      sync_q       <= 2'b00;
      frame_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      score0_q     <= score0_d;
      score1_q     <= score1_d;
      frames_q     <= frames_d;
      winner_q     <= winner_d;
      kill_q       <= kill_d;
      key_armed_q  <= key_armed_d;
      sync_q       <= {sync_q[0], frame_clk};
      frame_prev_q <= sync_q[1];
    end
  end

  assign state       = state_q;
  assign score0      = score0_q;
  assign score1      = score1_q;
  assign frames_left = frames_q;
  assign winner      = winner_q;
  assign bullet_kill = kill_q;
  assign tank_reset  = (state_q == StPlay || state_q == StHit) ? 2'b00 : 2'b11;
  assign freeze      = (state_q != StPlay);

endmodule

// File: tb/tb_tank_round_ctrl.sv
// Randomized bench for tank_round_ctrl against a frame-level game model.
module tb_tank_round_ctrl;

  logic       Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
  logic [7:0] keycode = 8'd0;
  logic [9:0] tank0_X = 10'd100, tank0_Y = 10'd100, tank1_X = 10'd480, tank1_Y = 10'd240;
  logic [9:0] bullet0_X = 10'd0, bullet0_Y = 10'd0, bullet1_X = 10'd0, bullet1_Y = 10'd0;
  logic       bullet0_active = 1'b0, bullet1_active = 1'b0;
  logic [1:0] tank_reset, bullet_kill;
  logic       freeze, winner;
  logic [3:0] score0, score1;
  logic [2:0] state;
  logic [7:0] frames_left;

  int checks = 0, failures = 0;
  // Model: 0 attract, 1 countdown, 2 play, 3 hit, 4 game over.
  int m_st, m_s0, m_s1, m_fl, m_win, m_kill, cur_key;
  bit m_armed;

  tank_round_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .tank0_X(tank0_X), .tank0_Y(tank0_Y), .tank1_X(tank1_X), .tank1_Y(tank1_Y),
    .bullet0_X(bullet0_X), .bullet0_Y(bullet0_Y), .bullet1_X(bullet1_X),
    .bullet1_Y(bullet1_Y), .bullet0_active(bullet0_active),
    .bullet1_active(bullet1_active), .tank_reset(tank_reset), .bullet_kill(bullet_kill),
    .freeze(freeze), .score0(score0), .score1(score1), .state(state),
    .frames_left(frames_left), .winner(winner)
  );

  always #10 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("state", int'(state), m_st);
    check("frames_left", int'(frames_left), m_fl);
    check("score0", int'(score0), m_s0);
    check("score1", int'(score1), m_s1);
    check("bullet_kill", int'(bullet_kill), m_kill);
    check("tank_reset", int'(tank_reset), (m_st == 2 || m_st == 3) ? 0 : 3);
    check("freeze", int'(freeze), (m_st == 2) ? 0 : 1);
    if (m_st == 4) check("winner", int'(winner), m_win);
  endtask

  function automatic bit hits(input int bx, input int by, input int tx, input int ty);
    return (bx + 8 >= tx) && (bx <= tx + 32) && (by + 8 >= ty) && (by <= ty + 32);
  endfunction

  task automatic model_reset();
    m_st = 0; m_s0 = 0; m_s1 = 0; m_fl = 0; m_win = 0; m_kill = 0; m_armed = 0;
  endtask

  task automatic model_fe();
    int  prev;
    bit  h0, h1;
    prev = m_st;
    h0 = bullet0_active && hits(bullet0_X, bullet0_Y, tank1_X, tank1_Y);
    h1 = bullet1_active && hits(bullet1_X, bullet1_Y, tank0_X, tank0_Y);
    case (m_st)
      1: if (m_fl <= 1) begin m_fl = 0; m_st = 2; end else m_fl--;
      2: if (h0 || h1) begin
        if (h0 && !h1 && m_s0 < 5) m_s0++;
        if (h1 && !h0 && m_s1 < 5) m_s1++;
        m_kill = 3; m_fl = 60; m_st = 3;
      end
      3: if (m_fl <= 1) begin
        m_kill = 0;
        if (m_s0 == 5 || m_s1 == 5) begin
          m_win = (m_s1 == 5) ? 1 : 0; m_fl = 0; m_st = 4;
        end else begin
          m_fl = 180; m_st = 1;
        end
      end else m_fl--;
      default: ;
    endcase
    if (m_st != prev) m_armed = (cur_key == 0);
  endtask

  task automatic frame_tick();
    if (cur_key == 0) m_armed = 1;
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    model_fe();
    check_all();
  endtask

  task automatic key_event(input int code);
    keycode = code[7:0];
    cur_key = code;
    repeat (3) @(negedge Clk);
    if (code == 0) m_armed = 1;
    else if (code == 'h28 && m_armed && (m_st == 0 || m_st == 4)) begin
      m_s0 = 0; m_s1 = 0; m_fl = 180; m_st = 1; m_armed = 0;
    end
    check_all();
  endtask

  task automatic do_reset(input int key);
    @(negedge Clk);
    keycode = key[7:0];
    cur_key = key;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    if (key == 0) m_armed = 1;
    check_all();
  endtask

  task automatic run_until(input int target);
    int n = 0;
    while (m_st != target && n < 1000) begin
      frame_tick();
      n++;
    end
    check("run_until_state", int'(state), target);
  endtask

  task automatic set_b0(input int x, input int y, input bit act);
    bullet0_X = x[9:0]; bullet0_Y = y[9:0]; bullet0_active = act;
  endtask

  task automatic set_b1(input int x, input int y, input bit act);
    bullet1_X = x[9:0]; bullet1_Y = y[9:0]; bullet1_active = act;
  endtask

  // One directed hit round: aim, take the hit frame, clear bullets, wait for play.
  task automatic hit_round(input int x, input int y);
    set_b0(x, y, 1);
    frame_tick();
    set_b0(0, 0, 0);
    set_b1(0, 0, 0);
    if (m_st == 3) begin
      repeat (59) frame_tick();
      frame_tick();
      if (m_st == 1) run_until(2);
    end
  endtask

  task automatic randomize_play();
    int tx0, ty0, tx1, ty1;
    tx0 = $urandom_range(20, 900); ty0 = $urandom_range(20, 420);
    tx1 = $urandom_range(20, 900); ty1 = $urandom_range(20, 420);
    tank0_X = tx0[9:0]; tank0_Y = ty0[9:0]; tank1_X = tx1[9:0]; tank1_Y = ty1[9:0];
    if ($urandom_range(0, 2) == 0)
      set_b0(tx1 + $urandom_range(0, 56) - 12, ty1 + $urandom_range(0, 56) - 12,
             $urandom_range(0, 3) != 0);
    else set_b0($urandom_range(0, 1000), $urandom_range(0, 470), $urandom_range(0, 1));
    if ($urandom_range(0, 2) == 0)
      set_b1(tx0 + $urandom_range(0, 56) - 12, ty0 + $urandom_range(0, 56) - 12,
             $urandom_range(0, 3) != 0);
    else set_b1($urandom_range(0, 1000), $urandom_range(0, 470), $urandom_range(0, 1));
  endtask

  initial begin
    int codes[3];
    codes[0] = 0; codes[1] = 'h28; codes[2] = 'h15;
    cur_key = 0;
    model_reset();

    do_reset(0);
    key_event('h28);
    key_event(0);

    // Start key held through reset must not start a game.
    do_reset('h28);
    repeat (5) @(negedge Clk);
    check_all();
    key_event(0);
    key_event('h28);
    key_event('h28);
    key_event(0);
    run_until(2);

    // Edge cases around tank1 at (480,240).
    set_b0(471, 240, 1); frame_tick();
    set_b0(513, 240, 1); frame_tick();
    hit_round(500, 250);
    hit_round(472, 240);
    hit_round(512, 240);
    set_b1(100, 100, 1);
    hit_round(500, 250);
    hit_round(490, 245);
    hit_round(490, 245);
    run_until(4);
    key_event('h28);
    key_event(0);

    for (int i = 0; i < 3000; i++) begin
      if (m_st == 2) randomize_play();
      if (m_st == 4) begin
        key_event(0);
        key_event('h28);
      end else if ($urandom_range(0, 15) == 0) begin
        key_event(codes[$urandom_range(0, 2)]);
      end
      frame_tick();
    end

    // Reset in the middle of a hit pause.
    key_event(0);
    if (m_st != 2) begin
      if (m_st == 0 || m_st == 4) key_event('h28);
      key_event(0);
      run_until(2);
    end
    tank0_X = 10'd100; tank0_Y = 10'd100; tank1_X = 10'd480; tank1_Y = 10'd240;
    set_b1(0, 0, 0);
    set_b0(500, 250, 1);
    frame_tick();
    set_b0(0, 0, 0);
    repeat (5) frame_tick();
    do_reset(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
